// File: rtl/seg_reader.sv
// seg_reader: samples a multiplexed 7-segment display and assembles stable digits into 16-bit frames
module seg_reader #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        seg_err,
  output logic        overrun
);
  typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;
  state_t state, state_nx;
  logic [6:0] seg_q;
  logic [3:0] an_q;
  logic [10:0] prev;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] mask, sel, nib;
  logic [15:0] buffer;
  logic legal, one_hot, same, acc, full;
  assign sel = ~an_q;
  assign one_hot = (an_q == 4'b1110) || (an_q == 4'b1101) || (an_q == 4'b1011) || (an_q == 4'b0111);
  assign same = {an_q, seg_q} == prev;
  assign full = mask == 4'hF;
  // input stage plus one-cycle history of the registered sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= '0;
      an_q <= '0;
      prev <= '0;
    end else begin
      seg_q <= seg;
      an_q <= an;
      prev <= {an_q, seg_q};
    end
  end
  // glyph table; anything not listed is flagged illegal
  always_comb begin
    legal = 1'b1;
    nib = 4'h0;
    case (seg_q)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // dwell state and stability counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // dwell tracking: accept once the same one-hot sample has been seen STABLE_CYC times in a row
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    acc = 1'b0;
    case (state)
      WAIT: if (one_hot) begin
        state_nx = COUNT;
        cnt_nx = 8'd1;
      end
      COUNT: if (!same) begin
        state_nx = WAIT;
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt + 8'd1;
        if (cnt == 8'(STABLE_CYC - 1)) begin
          state_nx = HELD;
          acc = 1'b1;
        end
      end
      HELD: if (!same) begin
        state_nx = WAIT;
        cnt_nx = '0;
      end
      default: begin
        state_nx = WAIT;
        cnt_nx = '0;
      end
    endcase
  end
  // frame buffer and capture mask; illegal glyphs invalidate their slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer <= '0;
      mask <= '0;
      seg_err <= 1'b0;
    end else begin
      seg_err <= acc && !legal;
      for (int i = 0; i < 4; i++)
        if (acc && legal && sel[i]) buffer[4*i +: 4] <= nib;
      if (full) mask <= '0;
      else if (acc) mask <= legal ? (mask | sel) : (mask & ~sel);
    end
  end
  // output holding register; a new frame always wins, losing an unread one sets overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
      word_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (full) begin
      word <= buffer;
      word_valid <= 1'b1;
      if (word_valid && !word_ready) overrun <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end
endmodule
